// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared cache package: line/burst geometry, beat counter types and the
// adaptor state encoding. Imported by the cache data array and the adaptor.
package cacheline_burst_adaptor_pkg;

  localparam int unsigned s_offset = 5;
  localparam int unsigned s_line   = 8 * (2 ** s_offset);
  localparam int unsigned s_burst  = 64;
  localparam int unsigned s_addr   = 32;
  localparam int unsigned n_beats  = s_line / s_burst;
  localparam int unsigned cnt_w    = $clog2(n_beats);
  localparam int unsigned bit_w    = $clog2(s_line);

  typedef logic [s_line-1:0]  line_t;
  typedef logic [s_burst-1:0] burst_t;
  typedef logic [s_addr-1:0]  addr_t;
  typedef logic [cnt_w-1:0]   cnt_t;
  typedef logic [bit_w-1:0]   bit_idx_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;

  // Bit position of the least significant bit of beat 'cnt' within a line.
  // Beat and line sizes are powers of two, so this is a plain shift.
  function automatic bit_idx_t beat_lsb(input cnt_t cnt);
    return bit_idx_t'(cnt) << $clog2(s_burst);
  endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Cache line <-> memory burst adaptor. One outstanding transaction at a time.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   line_i / line_o     write-back line from cache / assembled fill line to cache
//   address_i           cache request address (any byte in the line)
//   read_i / write_i    cache fill / write-back request, held until resp_o
//   resp_o              one-cycle completion pulse to the cache
//   burst_i / burst_o   read beat from memory / write beat to memory
//   address_o           line-aligned memory address
//   read_o / write_o    memory burst request
//   resp_i              memory beat strobe, one per beat, gaps allowed
//
// state | meaning
// IDLE  | waiting for a cache request; memory strobes ignored
// READ  | read_o high, each resp_i captures one beat into line_o
// WRITE | write_o high, burst_o shows current beat, each resp_i advances
// DONE  | resp_o high for one cycle, then back to IDLE
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  line_t  line_i,
  output line_t  line_o,
  input  addr_t  address_i,
  input  logic   read_i,
  input  logic   write_i,
  output logic   resp_o,
  input  burst_t burst_i,
  output burst_t burst_o,
  output addr_t  address_o,
  output logic   read_o,
  output logic   write_o,
  input  logic   resp_i
);

  localparam cnt_t last_beat = cnt_t'(n_beats - 1);

  adaptor_state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  line_t  line_q, line_d;
  line_t  wbuf_q, wbuf_d;
  burst_t burst_q, burst_d;
  addr_t  addr_q, addr_d;
  logic   read_q, read_d;
  logic   write_q, write_d;
  logic   resp_q, resp_d;
  cnt_t   cnt_nx;

  assign cnt_nx = cnt_t'(cnt_q + 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    wbuf_d  = wbuf_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Simultaneous read and write requests are resolved in favour of read.
        if (read_i) begin
          state_d = READ;
          addr_d  = {address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
          cnt_d   = '0;
          read_d  = 1'b1;
        end else if (write_i) begin
          state_d = WRITE;
          addr_d  = {address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
          cnt_d   = '0;
          wbuf_d  = line_i;
          burst_d = line_i[beat_lsb('0) +: s_burst];
          write_d = 1'b1;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[beat_lsb(cnt_q) +: s_burst] = burst_i;
          cnt_d = cnt_nx;
          if (cnt_q == last_beat) begin
            state_d = DONE;
            read_d  = 1'b0;
            resp_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_nx;
          if (cnt_q == last_beat) begin
            state_d = DONE;
            write_d = 1'b0;
            resp_d  = 1'b1;
          end else begin
            burst_d = wbuf_q[beat_lsb(cnt_nx) +: s_burst];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      wbuf_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      wbuf_q  <= wbuf_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign burst_o   = burst_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule
